shift_rows_pipe: RTL

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe.sv | 75 +++++++
 1 files changed

// File: rtl/shift_rows_pipe.sv
// AES ShiftRows / InvShiftRows for 4-, 6- or 8-column states. The mode is
// chosen per beat. There is one output register stage with a valid/ready
// handshake on both sides.
module shift_rows_pipe #(
  parameter int NB = 4,
  parameter int W  = 32 * NB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_inv
);

  localparam int NBYTES = 4 * NB;

  // Rijndael row offsets: the 256-bit block uses a wider spread on rows 2 and 3.
  function automatic int row_off(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      default: off = (NB == 8) ? 4 : 3;
    endcase
    return off;
  endfunction

  logic [W-1:0] fwd_data;
  logic [W-1:0] inv_data;
  logic [W-1:0] shifted_data;
  logic         in_fire;

  // Pure wiring. Each output byte picks a fixed source byte in each direction.
  // Byte k is element (k mod 4, k div 4), with byte 0 in the MSBs.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam int ROW     = gi % 4;
      localparam int COL     = gi / 4;
      localparam int OFF     = row_off(ROW);
      localparam int FWD_SRC = 4 * ((COL + OFF) % NB) + ROW;
      localparam int INV_SRC = 4 * ((COL - OFF + NB) % NB) + ROW;
      assign fwd_data[W-1-8*gi -: 8] = in_data[W-1-8*FWD_SRC -: 8];
      assign inv_data[W-1-8*gi -: 8] = in_data[W-1-8*INV_SRC -: 8];
    end
  endgenerate

  assign shifted_data = in_inv ? inv_data : fwd_data;

  // The register can take a new beat when it is empty or is draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Output register: a new beat loads, a drain without a refill clears valid, and otherwise the register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_inv   <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= shifted_data;
      out_inv   <= in_inv;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
